// File: rtl/cpu_mem_arbiter.sv
// Single-port RAM arbiter for fetch, load and store clients.
// One-entry store buffer absorbs store conflicts and forwards to loads.
module cpu_mem_arbiter #(
   parameter int AW = 11,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          read_mem_ir,
   input  logic [AW-1:0] mem_radrs_ir,
   output logic [DW-1:0] instruction_fetch,
   output logic          fetch_stall,
   input  logic          read_mem_str,
   input  logic [AW-1:0] mem_radrs_ld,
   output logic [DW-1:0] mem_store_data,
   input  logic          write_mem,
   input  logic [AW-1:0] mem_wadrs,
   input  logic [DW-1:0] mem_wdata,
   output logic          ram_en,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
   output logic          store_drop,
   output logic [15:0]   stall_count
);

   logic          buf_valid;
   logic [AW-1:0] buf_addr;
   logic [DW-1:0] buf_data;

   logic          g_ld;
   logic          g_buf;
   logic          g_st;
   logic          g_fe;

   logic          st_park;
   logic          st_fill;
   logic          st_lost;
   logic          hit_st;
   logic          hit_buf;

   logic          ld_pend;
   logic          ld_fwd;
   logic [DW-1:0] fwd_data;
   logic [DW-1:0] ld_hold;
   logic          fe_pend;

   always_comb begin
      g_ld  = 1'b0;
      g_buf = 1'b0;
      g_st  = 1'b0;
      g_fe  = 1'b0;
      if (!reset) begin
         if (read_mem_str)
            g_ld = 1'b1;
         else if (buf_valid)
            g_buf = 1'b1;
         else if (write_mem)
            g_st = 1'b1;
         else if (read_mem_ir)
            g_fe = 1'b1;
      end
   end

   always_comb begin
      ram_addr = mem_radrs_ir;
      if (g_ld)
         ram_addr = mem_radrs_ld;
      else if (g_buf)
         ram_addr = buf_addr;
      else if (g_st)
         ram_addr = mem_wadrs;
   end

   assign ram_en    = g_ld | g_buf | g_st | g_fe;
   assign ram_we    = g_buf | g_st;
   assign ram_wdata = g_buf ? buf_data : mem_wdata;

   assign fetch_stall = read_mem_ir & ~g_fe & ~reset;

   // A parked store may refill the buffer in the cycle it drains.
   assign st_park = write_mem & ~g_st;
   assign st_fill = st_park & (~buf_valid | g_buf);
   assign st_lost = st_park & buf_valid & ~g_buf;

   assign hit_st  = write_mem & (mem_wadrs == mem_radrs_ld);
   assign hit_buf = buf_valid & (buf_addr == mem_radrs_ld);

   always_ff @(posedge clk) begin
      if (reset) begin
         buf_valid   <= 1'b0;
         buf_addr    <= '0;
         buf_data    <= '0;
         store_drop  <= 1'b0;
         stall_count <= '0;
         ld_pend     <= 1'b0;
         ld_fwd      <= 1'b0;
         fwd_data    <= '0;
         ld_hold     <= '0;
         fe_pend     <= 1'b0;
      end else begin
         if (st_fill) begin
            buf_valid <= 1'b1;
            buf_addr  <= mem_wadrs;
            buf_data  <= mem_wdata;
         end else if (g_buf) begin
            buf_valid <= 1'b0;
         end

         if (st_lost)
            store_drop <= 1'b1;

         if (fetch_stall && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'd1;

         ld_pend  <= read_mem_str;
         ld_fwd   <= read_mem_str & (hit_st | hit_buf);
         fwd_data <= hit_st ? mem_wdata : buf_data;
         if (ld_pend)
            ld_hold <= mem_store_data;

         fe_pend <= g_fe;
      end
   end

   always_comb begin
      mem_store_data = ld_hold;
      if (ld_pend)
         mem_store_data = ld_fwd ? fwd_data : ram_rdata;
   end

   assign instruction_fetch = fe_pend ? ram_rdata : '0;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: directed table, random traffic against a
// program-order memory model, buffer/reset corners and counter saturation.
module tb_cpu_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        read_mem_ir;
   logic [10:0] mem_radrs_ir;
   logic [31:0] instruction_fetch;
   logic        fetch_stall;
   logic        read_mem_str;
   logic [10:0] mem_radrs_ld;
   logic [31:0] mem_store_data;
   logic        write_mem;
   logic [10:0] mem_wadrs;
   logic [31:0] mem_wdata;
   logic        ram_en;
   logic        ram_we;
   logic [10:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic        store_drop;
   logic [15:0] stall_count;

   always #5 clk = ~clk;

   cpu_mem_arbiter #(.AW(11), .DW(32)) dut (
      .clk(clk),
      .reset(reset),
      .read_mem_ir(read_mem_ir),
      .mem_radrs_ir(mem_radrs_ir),
      .instruction_fetch(instruction_fetch),
      .fetch_stall(fetch_stall),
      .read_mem_str(read_mem_str),
      .mem_radrs_ld(mem_radrs_ld),
      .mem_store_data(mem_store_data),
      .write_mem(write_mem),
      .mem_wadrs(mem_wadrs),
      .mem_wdata(mem_wdata),
      .ram_en(ram_en),
      .ram_we(ram_we),
      .ram_addr(ram_addr),
      .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata),
      .store_drop(store_drop),
      .stall_count(stall_count)
   );

   function automatic logic [31:0] init_word(input int i);
      if (i < 4)
         return 32'h11 * (i + 1);
      return 32'h1000_0000 + i;
   endfunction

   // Synchronous single-port RAM, preloaded on the first clock.
   logic [31:0] ram [2048];
   logic        loaded = 1'b0;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 2048; i++)
            ram[i] <= init_word(i);
         loaded <= 1'b1;
      end else if (ram_en) begin
         if (ram_we)
            ram[ram_addr] <= ram_wdata;
         else
            ram_rdata <= ram[ram_addr];
      end
   end

   // Reference model: RAM image, pending-store queue (capacity one).
   typedef struct {
      logic [10:0] a;
      logic [31:0] d;
   } st_t;

   logic [31:0] mram [2048];
   st_t         pend[$];
   logic        m_drop;
   int          m_sc;
   logic [31:0] m_if;
   logic [31:0] m_msd;

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic idle_inputs();
      read_mem_ir  = 1'b0;
      mem_radrs_ir = '0;
      read_mem_str = 1'b0;
      mem_radrs_ld = '0;
      write_mem    = 1'b0;
      mem_wadrs    = '0;
      mem_wdata    = '0;
   endtask

   task automatic model_reset();
      pend.delete();
      m_drop = 1'b0;
      m_sc   = 0;
      m_if   = '0;
      m_msd  = '0;
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      read_mem_str = 1'b1;
      write_mem    = 1'b1;
      read_mem_ir  = 1'b1;
      #1;
      chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
      chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle_inputs();
      model_reset();
      chk("rst_ifetch", instruction_fetch, 32'd0);
      chk("rst_msd", mem_store_data, 32'd0);
      chk("rst_sc", {16'd0, stall_count}, 32'd0);
      chk("rst_drop", {31'd0, store_drop}, 32'd0);
   endtask

   // One clock: drive, check RAM port, advance model, check returns.
   task automatic cycle(
      input  logic        l,
      input  logic [10:0] la,
      input  logic        s,
      input  logic [10:0] sa,
      input  logic [31:0] sd,
      input  logic        f,
      input  logic [10:0] fa,
      output logic        a_stall,
      output logic        a_we,
      output logic [10:0] a_addr,
      output logic [31:0] a_if,
      output logic [31:0] a_msd,
      output logic        a_drop,
      output logic [15:0] a_sc
   );
      logic        busy;
      logic        gb;
      logic        gs;
      logic        gf;
      logic        en;
      logic [10:0] ea;
      logic [31:0] ed;
      read_mem_str = l;
      mem_radrs_ld = la;
      write_mem    = s;
      mem_wadrs    = sa;
      mem_wdata    = sd;
      read_mem_ir  = f;
      mem_radrs_ir = fa;
      #1;
      busy = (pend.size() != 0);
      gb   = !l && busy;
      gs   = !l && !busy && s;
      gf   = !l && !busy && !s && f;
      en   = l || gb || gs || gf;
      ea   = l ? la : gb ? pend[0].a : gs ? sa : fa;
      ed   = gb ? pend[0].d : sd;
      chk("fetch_stall", {31'd0, fetch_stall}, {31'd0, f && !gf});
      chk("ram_en", {31'd0, ram_en}, {31'd0, en});
      if (en) begin
         chk("ram_we", {31'd0, ram_we}, {31'd0, gb || gs});
         chk("ram_addr", {21'd0, ram_addr}, {21'd0, ea});
      end
      if (gb || gs)
         chk("ram_wdata", ram_wdata, ed);
      a_stall = fetch_stall;
      a_we    = ram_we;
      a_addr  = ram_addr;

      if (l) begin
         if (s && sa == la)
            m_msd = sd;
         else if (busy && pend[0].a == la)
            m_msd = pend[0].d;
         else
            m_msd = mram[la];
      end
      m_if = gf ? mram[fa] : 32'd0;
      if (gb) begin
         mram[pend[0].a] = pend[0].d;
         void'(pend.pop_front());
      end
      if (gs)
         mram[sa] = sd;
      if (s && !gs) begin
         if (pend.size() == 0)
            pend.push_back('{a: sa, d: sd});
         else
            m_drop = 1'b1;
      end
      if (f && !gf && m_sc < 16'hFFFF)
         m_sc++;

      @(posedge clk);
      #1;
      chk("ifetch", instruction_fetch, m_if);
      chk("mem_store_data", mem_store_data, m_msd);
      chk("stall_count", {16'd0, stall_count}, m_sc);
      chk("store_drop", {31'd0, store_drop}, {31'd0, m_drop});
      a_if   = instruction_fetch;
      a_msd  = mem_store_data;
      a_drop = store_drop;
      a_sc   = stall_count;
   endtask

   typedef struct {
      logic        l;
      logic [10:0] la;
      logic        s;
      logic [10:0] sa;
      logic [31:0] sd;
      logic        f;
      logic [10:0] fa;
      logic        e_stall;
      logic        e_we;
      logic [10:0] e_addr;
      logic [31:0] e_if;
      logic [31:0] e_msd;
      logic        e_drop;
      logic [15:0] e_sc;
   } vec_t;

   vec_t tbl[16];

   logic        o_stall;
   logic        o_we;
   logic [10:0] o_addr;
   logic [31:0] o_if;
   logic [31:0] o_msd;
   logic        o_drop;
   logic [15:0] o_sc;

   initial begin
      tbl[0]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h11, 0, 0, 0};
      tbl[1]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 32'h22, 0, 0, 0};
      tbl[2]  = '{0, 0, 0, 0, 0, 1, 2, 0, 0, 2, 32'h33, 0, 0, 0};
      tbl[3]  = '{0, 0, 0, 0, 0, 1, 3, 0, 0, 3, 32'h44, 0, 0, 0};
      tbl[4]  = '{1, 11'h005, 0, 0, 0, 1, 11'h010,
                  1, 0, 11'h005, 0, 32'h1000_0005, 0, 1};
      tbl[5]  = '{1, 11'h020, 1, 11'h020, 32'hDEAD_BEEF, 0, 0,
                  0, 0, 11'h020, 0, 32'hDEAD_BEEF, 0, 1};
      tbl[6]  = '{0, 0, 0, 0, 0, 0, 0,
                  0, 1, 11'h020, 0, 32'hDEAD_BEEF, 0, 1};
      tbl[7]  = '{1, 11'h040, 1, 11'h030, 32'hA5, 0, 0,
                  0, 0, 11'h040, 0, 32'h1000_0040, 0, 1};
      tbl[8]  = '{1, 11'h030, 0, 0, 0, 0, 0,
                  0, 0, 11'h030, 0, 32'hA5, 0, 1};
      tbl[9]  = '{1, 11'h041, 1, 11'h050, 32'h77, 0, 0,
                  0, 0, 11'h041, 0, 32'h1000_0041, 1, 1};
      tbl[10] = '{1, 11'h050, 0, 0, 0, 0, 0,
                  0, 0, 11'h050, 0, 32'h1000_0050, 1, 1};
      tbl[11] = '{0, 0, 0, 0, 0, 0, 0,
                  0, 1, 11'h030, 0, 32'h1000_0050, 1, 1};
      tbl[12] = '{1, 11'h030, 0, 0, 0, 0, 0,
                  0, 0, 11'h030, 0, 32'hA5, 1, 1};
      tbl[13] = '{0, 0, 0, 0, 0, 1, 11'h030,
                  0, 0, 11'h030, 32'hA5, 32'hA5, 1, 1};
      tbl[14] = '{0, 0, 1, 11'h060, 32'h12, 1, 11'h061,
                  1, 1, 11'h060, 0, 32'hA5, 1, 2};
      tbl[15] = '{1, 11'h060, 0, 0, 0, 0, 0,
                  0, 0, 11'h060, 0, 32'h12, 1, 2};

      for (int i = 0; i < 2048; i++)
         mram[i] = init_word(i);
      model_reset();
      idle_inputs();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      do_reset();

      for (int i = 0; i < 16; i++) begin
         cycle(tbl[i].l, tbl[i].la, tbl[i].s, tbl[i].sa, tbl[i].sd,
               tbl[i].f, tbl[i].fa, o_stall, o_we, o_addr, o_if, o_msd,
               o_drop, o_sc);
         chk($sformatf("tbl%0d_stall", i), {31'd0, o_stall},
             {31'd0, tbl[i].e_stall});
         chk($sformatf("tbl%0d_we", i), {31'd0, o_we},
             {31'd0, tbl[i].e_we});
         chk($sformatf("tbl%0d_addr", i), {21'd0, o_addr},
             {21'd0, tbl[i].e_addr});
         chk($sformatf("tbl%0d_if", i), o_if, tbl[i].e_if);
         chk($sformatf("tbl%0d_msd", i), o_msd, tbl[i].e_msd);
         chk($sformatf("tbl%0d_drop", i), {31'd0, o_drop},
             {31'd0, tbl[i].e_drop});
         chk($sformatf("tbl%0d_sc", i), {16'd0, o_sc},
             {16'd0, tbl[i].e_sc});
      end

      // Pending store discarded by reset: never written, no drop.
      do_reset();
      cycle(1, 11'h070, 1, 11'h071, 32'hCAFE_0001, 0, 0,
            o_stall, o_we, o_addr, o_if, o_msd, o_drop, o_sc);
      #1;
      do_reset();
      cycle(0, 0, 0, 0, 0, 0, 0,
            o_stall, o_we, o_addr, o_if, o_msd, o_drop, o_sc);
      chk("rst_buf_no_write", {31'd0, ram_en}, 32'd0);
      cycle(1, 11'h071, 0, 0, 0, 0, 0,
            o_stall, o_we, o_addr, o_if, o_msd, o_drop, o_sc);
      chk("rst_buf_discarded", o_msd, 32'h1000_0071);

      // Random traffic on a small address window to force conflicts.
      for (int n = 0; n < 3000; n++) begin
         if (n % 700 == 699) begin
            #1;
            do_reset();
         end
         cycle($urandom_range(0, 2) == 0, 11'($urandom_range(0, 7)),
               $urandom_range(0, 2) == 0, 11'($urandom_range(0, 7)),
               $urandom, $urandom_range(0, 1) == 1,
               11'($urandom_range(0, 7)),
               o_stall, o_we, o_addr, o_if, o_msd, o_drop, o_sc);
      end

      // Fetch starved by a continuous load: counter must saturate.
      #1;
      do_reset();
      read_mem_str = 1'b1;
      mem_radrs_ld = 11'h000;
      read_mem_ir  = 1'b1;
      mem_radrs_ir = 11'h004;
      repeat (70000) @(posedge clk);
      #1;
      m_sc = 16'hFFFF;
      chk("sat_sc", {16'd0, stall_count}, m_sc);
      chk("sat_msd", mem_store_data, mram[0]);
      chk("sat_if", instruction_fetch, 32'd0);
      chk("sat_stall", {31'd0, fetch_stall}, 32'd1);
      do_reset();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Single-port memory arbiter between the pipelined CPU's three memory clients and one synchronous single-port RAM. The three clients are instruction fetch, load read and store write. It grants at most one RAM access per cycle and absorbs store conflicts in a one-entry store buffer with load forwarding. Denied fetches are returned as NOOP bubbles and flagged so the program counter can hold.

## Interface
- AW, 11, address width (matches CPU 11-bit addresses)
- DW, 32, data width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- read_mem_ir  in  1  fetch request
- mem_radrs_ir  in  AW  fetch address
- instruction_fetch  out  DW  fetched word, 1 cycle after grant; 0 (NOOP) otherwise
- fetch_stall  out  1  combinational; high when fetch requested but not granted this cycle
- read_mem_str  in  1  load request
- mem_radrs_ld  in  AW  load address
- mem_store_data  out  DW  load data, 1 cycle after request
- write_mem  in  1  store request
- mem_wadrs  in  AW  store address
- mem_wdata  in  DW  store data
- ram_en, ram_we  out  1 each  RAM access / write enable
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, valid 1 cycle after ram_en && !ram_we
- store_drop  out  1  sticky; set when a store was lost to buffer overflow
- stall_count  out  16  saturating count of fetch_stall cycles

## Operation
- Requests per cycle: L (load), B (buffered store pending), S (new store), F (fetch).
- Fixed priority L > B > S > F. Exactly one is granted per cycle; RAM port signals are combinational from the grant.
- Load always wins and is never stalled; the CPU has no load stall.
- S not granted: written into the store buffer (valid, addr, data).
  - B granted in the same cycle: the buffer drains and S refills it.
  - Buffer full and not draining: S is discarded and store_drop sets; it stays set until reset.
- B granted: RAM write from the buffer; valid clears unless refilled the same cycle.
- Load forwarding: the returned data source is selected by a register captured at request time, in this order:
  - same-cycle S with equal address: returns mem_wdata (the store is older in program order);
  - else valid buffer entry with equal address: returns buffer data as captured at request;
  - else ram_rdata.
- mem_store_data holds its last value when no load is outstanding.
- Fetch granted: instruction_fetch = ram_rdata next cycle. Fetch not granted, or no request: instruction_fetch = 0 next cycle.
- Fetch never reads a store-buffer entry. Self-modifying code is unsupported.
- stall_count increments on every fetch_stall cycle and saturates at 16'hFFFF.

## Timing
- Reset (synchronous, dominant over all requests):
  - buffer valid = 0, store_drop = 0, stall_count = 0;
  - load/fetch return-select registers cleared, so instruction_fetch = 0 and mem_store_data = 0 in the first post-reset cycle;
  - ram_en = ram_we = 0 while reset is high.
- Load latency 1: request in cycle N, data on mem_store_data throughout cycle N+1.
- Fetch latency 1: grant in N, word in N+1. fetch_stall is asserted in N.
- Store accepted in N:
  - direct: RAM written at the N edge;
  - buffered: written in the first later cycle with no load.
- Worst case with no loads: a store is in RAM within 2 cycles.
- Address compares are full AW bits. No wrap logic; addresses are passed unchanged.
- Reset mid-buffer: the pending store is discarded without setting store_drop.

## Test plan
- Reset, then fetch-only at addresses 0..3 with RAM preloaded 0x11..0x44 -> instruction_fetch = 0x11..0x44 one cycle later each; fetch_stall = 0; stall_count = 0.
- Load 0x005 concurrent with fetch 0x010 -> ram_addr = 0x005; fetch_stall = 1; next cycle instruction_fetch = 0 and mem_store_data = RAM[5]; stall_count = 1.
- Load 0x020 together with store 0x020 = 0xDEADBEEF -> next cycle mem_store_data = 0xDEADBEEF; following cycle buffer drains (ram_we = 1, ram_addr = 0x020).
- Store 0x030 = 0xA5 buffered behind a load; load 0x030 next cycle while the buffer is still held by another load -> mem_store_data = 0xA5.
- Buffer full with consecutive load cycles, new store arrives -> store_drop = 1 and stays 1; the original buffered value reaches RAM after the loads end.
- Hold fetch denied for 70000 cycles -> stall_count = 16'hFFFF, no wrap. Assert reset -> stall_count = 0, store_drop = 0, outputs 0.
